// File: rtl/gate_construct_pkg.sv
// Shared definitions for the gate_construct leaf logic block.
// Input vectors are packed {e,d,c,b,a}; GC_TRUTH is the golden table for checkers.
`timescale 1ns/1ps
package gate_construct_pkg;

  localparam int N_IN = 5;

  typedef logic [N_IN-1:0] gc_vec_t;

  // Bit i holds V for {e,d,c,b,a} == i, with V = (a & b) | (~c & (d ^ e)).
  localparam logic [31:0] GC_TRUTH = 32'h888F8F88;

endpackage

// File: rtl/gc_and_or_xor_net.sv
// Structural gate network: V = (a AND b) OR ((NOT c) AND (d XOR e)).
// Built from primitive gates so the netlist mirrors the exercise drawing.
`timescale 1ns/1ps
module gc_and_or_xor_net (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic d_i,
  input  logic e_i,
  output logic v_o
);

  logic n_ab;
  logic n_nc;
  logic n_de;
  logic n_t;

  and u_and_ab (n_ab, a_i, b_i);
  not u_not_c  (n_nc, c_i);
  xor u_xor_de (n_de, d_i, e_i);
  and u_and_t  (n_t, n_nc, n_de);
  or  u_or_v   (v_o, n_ab, n_t);

endmodule

// File: rtl/gate_construct.sv
// Five-input gate network with combinational and registered outputs plus valid.
// Define GATE_CONSTRUCT_IN_REG_EN to add an input register stage (o_v latency 2).
`timescale 1ns/1ps
module gate_construct
  import gate_construct_pkg::*;
#(
  parameter bit OUT_INV = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_d,
  input  logic i_e,
  output logic o_v_comb,
  output logic o_v,
  output logic o_vld
);

  gc_vec_t in_vec;
  gc_vec_t net_in;
  logic    net_v;
  logic    v_d;
  logic    v_q;
  logic    vld_d;
  logic    vld_q;

  assign in_vec = {i_e, i_d, i_c, i_b, i_a};

`ifdef GATE_CONSTRUCT_IN_REG_EN
  gc_vec_t in_q;
  logic    pre_vld_q;

  // NOTE: async reset lives in the sensitivity list; state uses <= so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_q      <= '0;
      pre_vld_q <= 1'b0;
    end else begin
      in_q      <= in_vec;
      pre_vld_q <= 1'b1;
    end
  end

  assign net_in = in_q;
  assign vld_d  = pre_vld_q;
`else
  assign net_in = in_vec;
  assign vld_d  = 1'b1;
`endif

  gc_and_or_xor_net u_net (
    .a_i (net_in[0]),
    .b_i (net_in[1]),
    .c_i (net_in[2]),
    .d_i (net_in[3]),
    .e_i (net_in[4]),
    .v_o (net_v)
  );

  // Inversion sits after the network so the gate structure stays fixed.
  assign v_d      = net_v ^ OUT_INV;
  assign o_v_comb = v_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_q   <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      vld_q <= vld_d;
    end
  end

  assign o_v   = v_q;
  assign o_vld = vld_q;

endmodule

// File: tb/tb_gate_construct.sv
// Directed self-checking bench for gate_construct (normal and OUT_INV instances).
// Handles both builds of GATE_CONSTRUCT_IN_REG_EN.
`timescale 1ns/1ps
module tb_gate_construct;

`ifdef GATE_CONSTRUCT_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // Hand-derived table of V = ab | ~c(d^e), bit index {e,d,c,b,a}.
  localparam logic [31:0] TRUTH = 32'h888F8F88;

  logic clk = 1'b0;
  logic rst_n;
  logic a, b, c, d, e;
  logic v_comb, v, vld;
  logic vi_comb, vi, vldi;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gate_construct #(.OUT_INV(1'b0)) u_dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_a      (a),
    .i_b      (b),
    .i_c      (c),
    .i_d      (d),
    .i_e      (e),
    .o_v_comb (v_comb),
    .o_v      (v),
    .o_vld    (vld)
  );

  gate_construct #(.OUT_INV(1'b1)) u_dut_inv (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_a      (a),
    .i_b      (b),
    .i_c      (c),
    .i_d      (d),
    .i_e      (e),
    .o_v_comb (vi_comb),
    .o_v      (vi),
    .o_vld    (vldi)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] cnt);
    {e, d, c, b, a} = cnt;
  endtask

  function automatic logic tv(input logic [4:0] cnt);
    logic [31:0] t;
    t = TRUTH;
    return t[cnt];
  endfunction

  // Apply a vector and wait until o_v_comb reflects it.
  task automatic apply_comb(input logic [4:0] cnt);
`ifdef GATE_CONSTRUCT_IN_REG_EN
    @(negedge clk);
    drive(cnt);
    @(posedge clk);
    #1;
`else
    drive(cnt);
    #1;
`endif
  endtask

  logic [4:0] spot_cnt [7] = '{5'd0, 5'd3, 5'd8, 5'd12, 5'd16, 5'd24, 5'd31};
  logic       spot_exp [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [4:0] lat_vec  [5] = '{5'd3, 5'd0, 5'd8, 5'd12, 5'd31};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with random inputs
    rst_n = 1'b0;
    drive(5'($urandom));
    repeat (3) @(posedge clk);
    drive(5'($urandom));
    #1;
    check("rst_o_v", v, 1'b0);
    check("rst_o_vld", vld, 1'b0);
    check("rst_inv_o_v", vi, 1'b0);
    check("rst_inv_o_vld", vldi, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(5'd0);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      check("vld_rise", vld, (k == LAT));
    end

    // Exhaustive sweep of the counter
    for (int i = 0; i < 32; i++) begin
      apply_comb(5'(i));
      check("sweep_comb", v_comb, tv(5'(i)));
      check("sweep_inv_comb", vi_comb, ~tv(5'(i)));
`ifndef GATE_CONSTRUCT_IN_REG_EN
      #1;
`endif
    end

    // Hand spot checks
    for (int i = 0; i < 7; i++) begin
      apply_comb(spot_cnt[i]);
      check("spot_comb", v_comb, spot_exp[i]);
      check("spot_inv_comb", vi_comb, ~spot_exp[i]);
    end

    // Registered latency: o_v follows each vector LAT edges later
    for (int j = 0; j < 5 + LAT - 1; j++) begin
      @(negedge clk);
      if (j < 5) drive(lat_vec[j]);
      @(posedge clk);
      #1;
      if (j >= LAT - 1) begin
        check("lat_o_v", v, tv(lat_vec[j-LAT+1]));
        check("lat_inv_o_v", vi, ~tv(lat_vec[j-LAT+1]));
      end
    end

    // Inputs change between edges, then async reset mid-cycle
    @(negedge clk);
    drive(5'd3);
    repeat (LAT) @(posedge clk);
    #1;
    check("pre_rst_o_v", v, 1'b1);
    #1;
    drive(5'd12);
    #1;
    check("hold_between_edges", v, 1'b1);
    drive(5'd16);
    rst_n = 1'b0;
    #1;
    check("async_rst_o_v", v, 1'b0);
    check("async_rst_o_vld", vld, 1'b0);
    check("async_rst_comb", v_comb, (LAT == 1) ? 1'b1 : 1'b0);
    check("async_rst_inv_o_v", vi, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    check("rerelease_vld", vld, 1'b1);
    check("rerelease_o_v", v, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
